// File: rtl/cpx_memory_responder.sv
// cpx_memory_responder: 32x16 memory image for the complex-number core with host load/run/dump port
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   address, wr_data, readwriteN       core access (readwriteN 1 = read, 0 = write)
//   rd_data                            core read data, combinational, 16'h0003 outside RUN
//   ld_valid, ld_data, ld_ready        host image load stream (accepted only in IDLE)
//   start, stop, core_run              host run control; core_run high while the core owns memory
//   dump_valid, dump_data, dump_addr,
//   dump_ready, done                   host image dump stream; done pulses after the last word
//   wr_count                           saturating count of core writes in the last run
module cpx_memory_responder #(
  parameter int DEPTH = 32,
  parameter int IDLE_LIMIT = 64,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        address,
  input  logic [15:0]       wr_data,
  input  logic              readwriteN,
  output logic [15:0]       rd_data,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  output logic              ld_ready,
  input  logic              start,
  input  logic              stop,
  output logic              core_run,
  output logic              dump_valid,
  output logic [15:0]       dump_data,
  output logic [4:0]        dump_addr,
  input  logic              dump_ready,
  output logic              done,
  output logic [WCNT_W-1:0] wr_count
);
  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;
  localparam int IW = $clog2(IDLE_LIMIT) + 1;
  state_t state, nxt;
  logic [4:0] ptr;
  logic [IW-1:0] idle_cnt;
  logic [15:0] mem [DEPTH];
  logic wr, ld, hs, last;
  always_comb begin
    wr = state == RUN && !readwriteN;
    ld = state == IDLE && ld_valid;
    hs = state == DUMP && dump_ready;
    last = hs && ptr == 5'd31;
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? ((stop || (!wr && idle_cnt == IW'(IDLE_LIMIT - 1))) ? DUMP : RUN) :
          (last ? IDLE : DUMP);
  end
  assign ld_ready = state == IDLE;
  assign core_run = state == RUN;
  assign dump_valid = state == DUMP;
  assign dump_addr = ptr;
  assign dump_data = mem[ptr];
  // outside RUN the core sees the end instruction so it parks
  assign rd_data = core_run ? mem[address] : 16'h0003;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      idle_cnt <= '0;
      wr_count <= '0;
      done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      done <= last;
      if (ld) mem[ptr] <= ld_data;
      if (wr) mem[address] <= wr_data;
      // a load coincident with start lands at the old ptr before ptr clears
      if (state == IDLE && start) begin
        ptr <= '0;
        idle_cnt <= '0;
        wr_count <= '0;
      end else if (ld || hs) ptr <= ptr + 5'd1;
      if (state == RUN) idle_cnt <= wr ? '0 : idle_cnt + IW'(1);
      if (wr && wr_count != '1) wr_count <= wr_count + WCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cpx_memory_responder.sv
// tb_cpx_memory_responder: vector table plus dump scoreboard for cpx_memory_responder
module tb_cpx_memory_responder;
  logic clk = 0, rst_n;
  logic [4:0] address;
  logic [15:0] wr_data, rd_data, ld_data, dump_data;
  logic readwriteN, ld_valid, ld_ready, start, stop, core_run, dump_valid, dump_ready, done;
  logic [4:0] dump_addr;
  logic [7:0] wr_count;
  cpx_memory_responder dut (
    .clk(clk), .rst_n(rst_n), .address(address), .wr_data(wr_data), .readwriteN(readwriteN),
    .rd_data(rd_data), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .stop(stop), .core_run(core_run), .dump_valid(dump_valid),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_ready(dump_ready), .done(done),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] a;
    logic rwn;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tv[6];
  int checks = 0, failures = 0;
  logic [15:0] ref_mem [32];
  logic [15:0] q[$];
  logic [4:0] mptr;
  int nwr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic load(input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1;
    ld_data = d;
    #1 chk("ld_ready", ld_ready, 1);
    ref_mem[mptr] = d;
    mptr++;
  endtask
  task automatic go();
    @(negedge clk);
    ld_valid = 0;
    start = 1;
    mptr = 0;
    nwr = 0;
    @(negedge clk);
    start = 0;
    #1 chk("core_run", core_run, 1);
  endtask
  task automatic push_image();
    for (int i = 0; i < 32; i++) q.push_back(ref_mem[i]);
  endtask
  task automatic halt();
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    #1 chk("enter_dump", dump_valid, 1);
    push_image();
  endtask
  task automatic dump(input int mode, input bit noise, input int abort_at);
    int ea = 0, cyc = 0;
    logic [3:0] pat = 4'b1001;
    while (q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      if (ea == abort_at) begin
        dump_ready = 0;
        return;
      end
      dump_ready = mode == 0 ? 1'b1 : pat[cyc % 4];
      start = noise;
      ld_valid = noise;
      ld_data = 16'hDEAD;
      #1;
      chk("dump_valid", dump_valid, 1);
      chk("dump_addr", dump_addr, ea);
      chk("dump_data", dump_data, q[0]);
      chk("rd_data_dump", rd_data, 16'h0003);
      if (dump_ready) begin
        void'(q.pop_front());
        ea++;
      end
      cyc++;
    end
    chk("dump_timeout", q.size(), 0);
    @(negedge clk);
    start = 0;
    ld_valid = 0;
    dump_ready = 0;
    #1;
    chk("done_pulse", done, 1);
    chk("back_idle", ld_ready, 1);
    @(negedge clk);
    #1 chk("done_clear", done, 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_dump_addr"}, dump_addr, 0);
    chk({tag, "_ld_ready"}, ld_ready, 1);
    chk({tag, "_rd_data"}, rd_data, 16'h0003);
  endtask
  initial begin
    int n;
    tv[0] = '{5'd5, 1'b1, 16'h0000, 16'h0505};
    tv[1] = '{5'd9, 1'b0, 16'h1234, 16'h0909};
    tv[2] = '{5'd9, 1'b1, 16'h0000, 16'h1234};
    tv[3] = '{5'd31, 1'b1, 16'h0000, 16'h1F1F};
    tv[4] = '{5'd0, 1'b0, 16'hABCD, 16'h0000};
    tv[5] = '{5'd0, 1'b1, 16'h0000, 16'hABCD};
    rst_n = 0;
    address = 0; wr_data = 0; readwriteN = 1; ld_valid = 0; ld_data = 0;
    start = 0; stop = 0; dump_ready = 0; mptr = 0; nwr = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 0;
    #12 reset_checks("reset");
    @(negedge clk);
    rst_n = 1;
    // T1: load ramp, run without writes, dump
    for (int k = 0; k < 32; k++) load(16'(k * 16'h0101));
    go();
    halt();
    dump(0, 0, -1);
    chk("t1_wr_count", wr_count, 0);
    // T2: core access vectors in RUN
    go();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      address = tv[i].a;
      readwriteN = tv[i].rwn;
      wr_data = tv[i].wd;
      #1 chk($sformatf("vec%0d_rd", i), rd_data, tv[i].exp_rd);
      if (!tv[i].rwn) begin
        ref_mem[tv[i].a] = tv[i].wd;
        nwr++;
      end
    end
    @(negedge clk);
    readwriteN = 1;
    #1 chk("t2_wr_count", wr_count, nwr);
    halt();
    dump(0, 0, -1);
    chk("t2_wr_count_hold", wr_count, nwr);
    // T3: idle timeout, then T4: throttled dump with ignored start/load
    go();
    n = 0;
    while (!dump_valid && n < 200) begin
      @(negedge clk);
      n++;
      #1;
    end
    chk("idle_exit_cycles", n, 64);
    push_image();
    dump(1, 1, -1);
    // T5: 33 loads wrap, core access in IDLE has no effect
    address = 0;
    wr_data = 16'hFFFF;
    readwriteN = 0;
    for (int k = 0; k < 33; k++) begin
      load(16'(16'h5000 + k));
      chk("idle_rd_data", rd_data, 16'h0003);
    end
    @(negedge clk);
    readwriteN = 1;
    ld_valid = 0;
    go();
    halt();
    dump(0, 0, -1);
    // T6: reset in the middle of a dump
    go();
    @(negedge clk);
    address = 3;
    readwriteN = 0;
    wr_data = 16'h7777;
    ref_mem[3] = 16'h7777;
    @(negedge clk);
    readwriteN = 1;
    #1 chk("t6_wr_count", wr_count, 1);
    halt();
    dump(0, 0, 12);
    #1 chk("t6_pre_reset_addr", dump_addr, 12);
    #1 rst_n = 0;
    #1 reset_checks("midreset");
    q.delete();
    for (int i = 0; i < 32; i++) ref_mem[i] = 0;
    mptr = 0;
    @(negedge clk);
    rst_n = 1;
    go();
    halt();
    dump(0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
